// File: rtl/config_loader.sv
// Serial configuration loader: streams MSB-first words into a scan chain and
// packs the chain's previous contents, captured from its tail, back into words.
module config_loader #(
  parameter int CHAIN_LEN = 64,
  parameter int WORD_W    = 8
) (
  input  logic              scan_clk,
  input  logic              scan_rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [WORD_W-1:0] cfg_data,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  output logic              scan_en,
  output logic              scan_in,
  input  logic              scan_out,
  output logic [WORD_W-1:0] rb_data,
  output logic              rb_valid,
  output logic              busy,
  output logic              done,
  output logic              aborted
);

  localparam int CNT_W = $clog2(CHAIN_LEN + 1);
  localparam int BUF_W = $clog2(WORD_W + 1);
  localparam int PK_W  = $clog2(WORD_W);

  localparam logic [CNT_W-1:0] LAST_C    = CNT_W'(CHAIN_LEN - 1);
  localparam logic [BUF_W-1:0] FULL_C    = BUF_W'(WORD_W);
  localparam logic [PK_W-1:0]  PK_LAST_C = PK_W'(WORD_W - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t            state_r;
  state_t            state_nxt_s;

  logic [CNT_W-1:0]  bit_cnt_r;
  logic [CNT_W-1:0]  cap_cnt_r;
  logic [WORD_W-1:0] buf_r;
  logic [BUF_W-1:0]  buf_cnt_r;
  logic [WORD_W-2:0] pack_r;
  logic [PK_W-1:0]   pack_cnt_r;

  logic              scan_en_r;
  logic              scan_in_r;
  logic [WORD_W-1:0] rb_data_r;
  logic              rb_valid_r;
  logic              busy_r;
  logic              done_r;
  logic              aborted_r;

  logic              in_load_s;
  logic              have_bit_s;
  logic              last_bit_s;
  logic              cfg_ready_s;
  logic              xfer_s;
  logic              abort_s;
  logic              enter_load_s;
  logic              cap_last_s;
  logic              cap_full_s;
  logic [WORD_W-1:0] cap_word_s;
  logic [PK_W-1:0]   pad_sh_s;

  // Issue/handshake decode; a word may be taken while the buffer's last bit goes out.
  always_comb begin
    in_load_s   = (state_r == ST_LOAD);
    have_bit_s  = in_load_s && (buf_cnt_r != {BUF_W{1'b0}});
    last_bit_s  = have_bit_s && (bit_cnt_r == LAST_C);
    abort_s     = in_load_s && abort;
    if (!in_load_s) begin
      cfg_ready_s = 1'b0;
    end else if (buf_cnt_r == {BUF_W{1'b0}}) begin
      cfg_ready_s = 1'b1;
    end else if (buf_cnt_r == BUF_W'(1)) begin
      cfg_ready_s = !last_bit_s;
    end else begin
      cfg_ready_s = 1'b0;
    end
    xfer_s       = cfg_valid && cfg_ready_s;
    cap_last_s   = (cap_cnt_r == LAST_C);
    cap_full_s   = (pack_cnt_r == PK_LAST_C);
    cap_word_s   = {pack_r, scan_out};
    pad_sh_s     = PK_LAST_C - pack_cnt_r;
  end

  // State register.
  always_ff @(posedge scan_clk or negedge scan_rst_n) begin
    if (!scan_rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic; abort outranks both start and chain completion.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start) state_nxt_s = ST_LOAD;
        else       state_nxt_s = ST_IDLE;
      end
      ST_LOAD: begin
        if (abort)           state_nxt_s = ST_IDLE;
        else if (last_bit_s) state_nxt_s = ST_DONE;
        else                 state_nxt_s = ST_LOAD;
      end
      ST_DONE: begin
        if (start) state_nxt_s = ST_LOAD;
        else       state_nxt_s = ST_DONE;
      end
      default: state_nxt_s = ST_IDLE;
    endcase
    enter_load_s = (state_nxt_s == ST_LOAD) && (state_r != ST_LOAD);
  end

  // Shift-out, readback packing and status registers.
  always_ff @(posedge scan_clk or negedge scan_rst_n) begin
    if (!scan_rst_n) begin
      bit_cnt_r  <= {CNT_W{1'b0}};
      cap_cnt_r  <= {CNT_W{1'b0}};
      buf_r      <= {WORD_W{1'b0}};
      buf_cnt_r  <= {BUF_W{1'b0}};
      pack_r     <= {(WORD_W-1){1'b0}};
      pack_cnt_r <= {PK_W{1'b0}};
      scan_en_r  <= 1'b0;
      scan_in_r  <= 1'b0;
      rb_data_r  <= {WORD_W{1'b0}};
      rb_valid_r <= 1'b0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      aborted_r  <= 1'b0;
    end else begin
      rb_valid_r <= 1'b0;
      aborted_r  <= abort_s;
      busy_r     <= (state_nxt_s == ST_LOAD);
      done_r     <= (state_nxt_s == ST_DONE);

      if (abort_s) begin
        scan_en_r <= 1'b0;
        buf_cnt_r <= {BUF_W{1'b0}};
      end else if (have_bit_s) begin
        scan_en_r <= 1'b1;
        scan_in_r <= buf_r[WORD_W-1];
        buf_r     <= {buf_r[WORD_W-2:0], 1'b0};
        bit_cnt_r <= bit_cnt_r + CNT_W'(1);
        // Leftover low bits of a final partial word are dropped here.
        buf_cnt_r <= last_bit_s ? {BUF_W{1'b0}} : (buf_cnt_r - BUF_W'(1));
      end else begin
        scan_en_r <= 1'b0;
      end

      if (!abort_s && xfer_s) begin
        buf_r     <= cfg_data;
        buf_cnt_r <= FULL_C;
      end

      if (abort_s) begin
        pack_r     <= {(WORD_W-1){1'b0}};
        pack_cnt_r <= {PK_W{1'b0}};
      end else if (scan_en_r) begin
        cap_cnt_r <= cap_cnt_r + CNT_W'(1);
        if (cap_full_s || cap_last_s) begin
          // pad_sh_s is zero for a full word, so one shift handles both cases.
          rb_valid_r <= 1'b1;
          rb_data_r  <= cap_word_s << pad_sh_s;
          pack_r     <= {(WORD_W-1){1'b0}};
          pack_cnt_r <= {PK_W{1'b0}};
        end else begin
          pack_r     <= cap_word_s[WORD_W-2:0];
          pack_cnt_r <= pack_cnt_r + PK_W'(1);
        end
      end

      if (enter_load_s) begin
        bit_cnt_r  <= {CNT_W{1'b0}};
        cap_cnt_r  <= {CNT_W{1'b0}};
        buf_r      <= {WORD_W{1'b0}};
        buf_cnt_r  <= {BUF_W{1'b0}};
        pack_r     <= {(WORD_W-1){1'b0}};
        pack_cnt_r <= {PK_W{1'b0}};
      end
    end
  end

  assign cfg_ready = cfg_ready_s;
  assign scan_en   = scan_en_r;
  assign scan_in   = scan_in_r;
  assign rb_data   = rb_data_r;
  assign rb_valid  = rb_valid_r;
  assign busy      = busy_r;
  assign done      = done_r;
  assign aborted   = aborted_r;

endmodule

// File: doc/config_loader.md
CONFIG_LOADER -- requirements
Module: config_loader

Interface
REQ-001 Parameter CHAIN_LEN, default 64: number of scan bits in the downstream connection-box chain (1..4096).
REQ-002 Parameter WORD_W, default 8: configuration word width in bits (2..32).
REQ-003 Port scan_clk  input  1: the single clock; all state is updated on its rising edge.
REQ-004 Port scan_rst_n  input  1: reset, asynchronous and active-low.
REQ-005 Port start  input  1: one-cycle request to begin a load pass.
REQ-006 Port abort  input  1: one-cycle request to terminate the current load pass.
REQ-007 Port cfg_data  input  WORD_W: configuration word, transmitted MSB first.
REQ-008 Port cfg_valid  input  1: cfg_data is valid.
REQ-009 Port cfg_ready  output  1: the loader accepts cfg_data this cycle.
REQ-010 Port scan_en  output  1: shift enable to the chain; registered.
REQ-011 Port scan_in  output  1: serial data to the chain head; registered.
REQ-012 Port scan_out  input  1: serial data from the chain tail.
REQ-013 Port rb_data  output  WORD_W: packed readback of the chain's previous contents.
REQ-014 Port rb_valid  output  1: one-cycle strobe marking rb_data as valid.
REQ-015 Port busy  output  1: high in LOAD.
REQ-016 Port done  output  1: high in DONE.
REQ-017 Port aborted  output  1: one-cycle pulse when a pass ends by abort.

Function
REQ-018 The FSM SHALL have three states: IDLE, LOAD and DONE.
REQ-019 IDLE->LOAD on start; DONE->LOAD on start; LOAD->DONE on the edge that issues bit CHAIN_LEN; LOAD->IDLE on abort.
REQ-020 Entering LOAD SHALL clear bit_cnt, the word buffer and the readback packer.
REQ-021 A word transfer SHALL occur only when cfg_valid && cfg_ready are both high on the same edge.
REQ-022 cfg_ready SHALL be high only in LOAD, and only when the word buffer is empty or its last bit is being issued this cycle; this allows back-to-back words with no bubble.
REQ-023 Each edge in LOAD with a buffered bit SHALL register scan_en=1 and scan_in=the current MSB-first bit, and SHALL increment bit_cnt.
REQ-024 When the buffer is empty (starvation), scan_en SHALL register 0; the chain holds its state and bit_cnt holds.
REQ-025 bit_cnt SHALL be $clog2(CHAIN_LEN+1) bits wide and SHALL saturate at CHAIN_LEN.
REQ-026 If CHAIN_LEN mod WORD_W != 0, the unused low-order bits of the final word SHALL be discarded; cfg_ready SHALL drop once CHAIN_LEN bits have been issued.
REQ-027 On each edge where the registered scan_en is 1, scan_out SHALL be shifted into the readback packer at its LSB.
REQ-028 rb_valid SHALL pulse the cycle after every WORD_W captured bits. After the final capture, a partial word SHALL be emitted zero-padded in its low bits, so the first captured bit stays at the MSB.
REQ-029 The number of captured bits SHALL equal CHAIN_LEN per completed pass.
REQ-030 Abort in LOAD SHALL register scan_en=0 on the next edge, pulse aborted, and discard buffered and readback bits; no rb_valid SHALL follow.
REQ-031 start in LOAD SHALL be ignored; abort outside LOAD SHALL be ignored.
REQ-032 When start and abort occur in the same cycle in LOAD, abort SHALL win.
REQ-033 done SHALL be held high in DONE until the next start.

Reset
REQ-034 While scan_rst_n=0, regardless of clock, the block SHALL be in state IDLE with scan_en, scan_in, cfg_ready, rb_valid, busy, done and aborted all 0, rb_data=0 and bit_cnt=0.
REQ-035 Reset asserted mid-LOAD SHALL immediately force scan_en=0 and discard the partial pass.
REQ-036 The first start is accepted on the first rising edge after scan_rst_n deasserts.

Verification
REQ-037 CHAIN_LEN=16, WORD_W=8, words 0xA5 and 0x3C with continuous cfg_valid -> 16 consecutive scan_en cycles, scan_in=1010010100111100, done high after bit 16, no bubble between words.
REQ-038 Same setup, with cfg_valid held low 3 cycles between the two words -> scan_en low exactly 3 cycles, bit_cnt held, final chain contents identical to REQ-037.
REQ-039 Chain preloaded with 0xF00F, then load 0x0000 -> rb_valid twice, rb_data=0xF0 then 0x0F (tail-first order) after a model chain of 16 flops.
REQ-040 CHAIN_LEN=12, WORD_W=8, words 0xFF and 0xA0 -> scan_in=111111111010 (12 bits), cfg_ready low after the second word, second rb_data zero-padded in its low 4 bits.
REQ-041 abort after 5 bits -> scan_en=0 next cycle, aborted pulses once, no further rb_valid, state IDLE; a subsequent start reloads from bit 0.
REQ-042 scan_rst_n pulled low asynchronously mid-word -> scan_en, busy and cfg_ready go to 0 before the next clock edge, and all outputs read their reset values.
